// File: rtl/pair_pkg.sv
// Shared constants and state encoding for the pair accumulator / pair drain blocks.
package pair_pkg;

   localparam int unsigned PAIR_W      = 8;
   localparam int unsigned PAIR_X_BASE = 2;
   localparam int unsigned PAIR_X_STEP = 2;
   localparam int unsigned PAIR_Y_STEP = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } pair_state_e;

endpackage

// File: rtl/pair_drain_if.sv
// Load/step/status bundle between a pair producer and the pair_drain block.
interface pair_drain_if
   import pair_pkg::*;
#(
   parameter int unsigned W = PAIR_W
);
   logic         load_valid;
   logic         load_ready;
   logic [W-1:0] x_in;
   logic [W-1:0] y_in;
   logic         selector;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         busy;
   logic         done;
   logic         err;

   modport master (
      output load_valid, x_in, y_in, selector,
      input  load_ready, x, y, busy, done, err
   );

   modport slave (
      input  load_valid, x_in, y_in, selector,
      output load_ready, x, y, busy, done, err
   );
endinterface

// File: rtl/pair_drain_inv_check.sv
// Combinational pair invariant comparator: ok when x_in == X_BASE + X_STEP*y_in (mod 2^W).
module pair_inv_check
   import pair_pkg::*;
#(
   parameter int unsigned W      = PAIR_W,
   parameter int unsigned X_BASE = PAIR_X_BASE,
   parameter int unsigned X_STEP = PAIR_X_STEP
) (
   input  logic [W-1:0] x_in,
   input  logic [W-1:0] y_in,
   output logic         ok
);
   localparam logic [2*W-1:0] LOW_MASK = {{W{1'b0}}, {W{1'b1}}};

   logic [2*W-1:0] expect_wide;

   // Product formed at double width, then compared modulo 2^W.
   always_comb begin
      expect_wide = (2*W)'(X_BASE) + ((2*W)'(X_STEP) * (2*W)'(y_in));
      ok          = ({{W{1'b0}}, x_in} == (expect_wide & LOW_MASK));
   end
endmodule

// File: rtl/pair_drain.sv
// pair_drain: accepts an (x, y) pair and walks it down by X_STEP / Y_STEP per selector
// pulse until y saturates at 0, then pulses done for one cycle.
// Optional load-time invariant checker enabled by macro PAIR_DRAIN_CHECK_EN.
module pair_drain
   import pair_pkg::*;
#(
   parameter int unsigned W      = PAIR_W,
   parameter int unsigned X_BASE = PAIR_X_BASE,
   parameter int unsigned X_STEP = PAIR_X_STEP,
   parameter int unsigned Y_STEP = PAIR_Y_STEP
) (
   input  logic         clk,
   input  logic         rst,
   pair_drain_if.slave  bus
);
   localparam logic [W-1:0] X_BASE_W = W'(X_BASE);
   localparam logic [W-1:0] X_STEP_W = W'(X_STEP);
   localparam logic [W-1:0] Y_STEP_W = W'(Y_STEP);

   pair_state_e  state_q, state_d;
   logic [W-1:0] x_q, x_d;
   logic [W-1:0] y_q, y_d;
   logic         done_q, done_d;
   logic         inv_ok;

`ifdef PAIR_DRAIN_CHECK_EN
   logic err_q, err_d;

   pair_inv_check #(
      .W      (W),
      .X_BASE (X_BASE),
      .X_STEP (X_STEP)
   ) u_inv_check (
      .x_in (bus.x_in),
      .y_in (bus.y_in),
      .ok   (inv_ok)
   );

   // Sticky error: set on any rejected load, cleared only by reset.
   always_comb begin
      err_d = err_q | ((state_q == IDLE) && bus.load_valid && !inv_ok);
   end

   // Error flag register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign bus.err = err_q;
`else
   assign inv_ok  = 1'b1;
   assign bus.err = 1'b0;
`endif

   // Next-state, datapath and done-pulse computation.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.load_valid && inv_ok) begin
               x_d = bus.x_in;
               y_d = bus.y_in;
               if (bus.y_in == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (bus.selector) begin
               if (y_q <= Y_STEP_W) begin
                  x_d     = X_BASE_W;
                  y_d     = '0;
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  x_d = x_q - X_STEP_W;
                  y_d = y_q - Y_STEP_W;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         x_q     <= X_BASE_W;
         y_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         done_q  <= done_d;
      end
   end

   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.done       = done_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.load_ready = (state_q == IDLE);
endmodule

// File: tb/tb_pair_drain.sv
// Self-checking bench for pair_drain: directed vector table, hand-written reset and
// invariant sequences, and a randomized run against a behavioural reference model.
module tb_pair_drain;
   import pair_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   pair_drain_if #(.W(8)) bus ();

   pair_drain #(
      .W      (8),
      .X_BASE (2),
      .X_STEP (2),
      .Y_STEP (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       lv;
      logic [7:0] xi;
      logic [7:0] yi;
      logic       sel;
      logic [7:0] ex;
      logic [7:0] ey;
      logic       ebusy;
      logic       edone;
      logic       erdy;
   } vec_t;

   // Reference model: phase 0 = waiting for a load, 1 = counting down, 2 = finishing.
   int m_phase;
   int mx;
   int my;
   int merr;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input int ex, input int ey, input int ebusy,
                          input int edone, input int erdy, input int eerr);
      chk({tag, ".x"},          int'(bus.x),          ex);
      chk({tag, ".y"},          int'(bus.y),          ey);
      chk({tag, ".busy"},       int'(bus.busy),       ebusy);
      chk({tag, ".done"},       int'(bus.done),       edone);
      chk({tag, ".load_ready"}, int'(bus.load_ready), erdy);
      chk({tag, ".err"},        int'(bus.err),        eerr);
   endtask

   function automatic bit pair_valid(input int xi, input int yi);
`ifdef PAIR_DRAIN_CHECK_EN
      return xi == ((2 + 2 * yi) % 256);
`else
      return 1'b1;
`endif
   endfunction

   // Advance the model across one rising edge given the inputs being driven.
   task automatic model_edge(input int lv, input int xi, input int yi, input int sel);
      if (m_phase == 0) begin
         if (lv != 0) begin
            if (pair_valid(xi, yi)) begin
               mx = xi;
               my = yi;
               m_phase = (yi == 0) ? 2 : 1;
            end else begin
               merr = 1;
            end
         end
      end else if (m_phase == 1) begin
         if (sel != 0) begin
            if (my <= 1) begin
               mx = 2;
               my = 0;
               m_phase = 2;
            end else begin
               mx = (mx + 256 - 2) % 256;
               my = my - 1;
            end
         end
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic drive(input logic lv, input logic [7:0] xi, input logic [7:0] yi, input logic sel);
      bus.load_valid = lv;
      bus.x_in       = xi;
      bus.y_in       = yi;
      bus.selector   = sel;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(1'b0, 8'd0, 8'd0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      m_phase = 0;
      mx = 2;
      my = 0;
      merr = 0;
   endtask

   vec_t vecs[17];

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      drive(1'b0, 8'd0, 8'd0, 1'b0);

      // Reset values while reset is held.
      repeat (2) @(negedge clk);
      chk_all("reset", 2, 0, 0, 0, 1, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_reset.load_ready", int'(bus.load_ready), 1);

      //          lv    xi      yi       sel   ex       ey       busy  done  rdy
      vecs[0]  = '{1'b1, 8'd8,   8'd3,   1'b1, 8'd8,   8'd3,   1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd6,   8'd2,   1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd4,   8'd1,   1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd2,   8'd0,   1'b1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd2,   8'd0,   1'b0, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 8'd8,   8'd3,   1'b0, 8'd8,   8'd3,   1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd6,   8'd2,   1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 8'd0,   8'd0,   1'b0, 8'd6,   8'd2,   1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'd0,   8'd0,   1'b0, 8'd6,   8'd2,   1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd4,   8'd1,   1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd2,   8'd0,   1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 8'd0,   8'd0,   1'b0, 8'd2,   8'd0,   1'b0, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 8'd2,   8'd0,   1'b1, 8'd2,   8'd0,   1'b1, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd2,   8'd0,   1'b0, 1'b0, 1'b1};
      vecs[14] = '{1'b1, 8'd0,   8'd127, 1'b0, 8'd0,   8'd127, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd254, 8'd126, 1'b1, 1'b0, 1'b0};
      vecs[16] = '{1'b1, 8'd9,   8'd9,   1'b0, 8'd254, 8'd126, 1'b1, 1'b0, 1'b0};

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].lv, vecs[i].xi, vecs[i].yi, vecs[i].sel);
         @(posedge clk);
         @(negedge clk);
         chk_all($sformatf("vec%0d", i), int'(vecs[i].ex), int'(vecs[i].ey),
                 int'(vecs[i].ebusy), int'(vecs[i].edone), int'(vecs[i].erdy), 0);
      end

      // Reset mid-drain: load 8,3, step once, then assert reset between edges.
      do_reset();
      drive(1'b1, 8'd8, 8'd3, 1'b0);
      @(negedge clk);
      drive(1'b0, 8'd0, 8'd0, 1'b1);
      @(negedge clk);
      chk("middrain.y_before_reset", int'(bus.y), 2);
      drive(1'b0, 8'd0, 8'd0, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk_all("middrain_reset", 2, 0, 0, 0, 1, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_all("after_middrain_reset", 2, 0, 0, 0, 1, 0);
      end

      // Non-invariant pair 5,1 loaded from the reset point.
      do_reset();
      drive(1'b1, 8'd5, 8'd1, 1'b0);
      @(negedge clk);
`ifdef PAIR_DRAIN_CHECK_EN
      chk_all("badpair_load", 2, 0, 0, 0, 1, 1);
      drive(1'b0, 8'd0, 8'd0, 1'b1);
      @(negedge clk);
      chk_all("badpair_sticky", 2, 0, 0, 0, 1, 1);
`else
      chk_all("badpair_load", 5, 1, 1, 0, 0, 0);
      drive(1'b0, 8'd0, 8'd0, 1'b1);
      @(negedge clk);
      chk_all("badpair_step", 2, 0, 1, 1, 0, 0);
`endif

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic       lv;
         logic       sel;
         logic [7:0] yi;
         logic [7:0] xi;
         lv  = ($urandom_range(0, 3) == 0);
         sel = $urandom_range(0, 1);
         yi  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
         xi  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(2 + 2 * int'(yi));
         drive(lv, xi, yi, sel);
         model_edge(int'(lv), int'(xi), int'(yi), int'(sel));
         @(posedge clk);
         @(negedge clk);
         chk_all("rand", mx, my, (m_phase != 0) ? 1 : 0, (m_phase == 2) ? 1 : 0,
                 (m_phase == 0) ? 1 : 0, merr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
